// File: rtl/imem_stream_loader_pkg.sv
// Shared definitions for the instruction-memory stream loader.
// Contents:
//   state_t          loader FSM states
//   FRAME_HDR_BYTES  bytes in the frame length header (len_lo, len_hi)
//   BYTES_PER_WORD   payload bytes per instruction word
package loader_pkg;

  typedef enum logic [2:0] {
    LEN_LO = 3'd0,
    LEN_HI = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  localparam int FRAME_HDR_BYTES = 2;
  localparam int BYTES_PER_WORD  = 4;

endpackage

// File: rtl/imem_stream_loader.sv
// Instruction-memory stream loader.
// Takes a framed byte stream (len_lo, len_hi, 4*N payload bytes, XOR checksum)
// over a valid/ready handshake and writes the payload into a byte-wide
// instruction memory starting at BASE_ADDR, one cycle after each byte is
// accepted. The processor is held in reset until a frame loads cleanly.
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   start             one-cycle re-arm pulse, honoured only in DONE or ERROR
//   in_valid/in_data  byte source
//   in_ready          loader can take a byte (decoded from the state register)
//   mem_we/mem_addr/mem_wdata  registered byte write port
//   cpu_reset         processor reset, low only in DONE
//   done, error       frame outcome flags
//   words_loaded      complete words written in the current frame
//
// States:
//   LEN_LO | waiting for N[7:0]
//   LEN_HI | waiting for N[15:8], then length check
//   DATA   | receiving payload bytes, one memory write per byte
//   CSUM   | waiting for the checksum byte
//   DONE   | frame good, processor released
//   ERROR  | frame rejected, processor held in reset
module imem_stream_loader
  import loader_pkg::*;
#(
  parameter int IMEM_BYTES = 1024,
  parameter int ADDR_W     = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  localparam int CAP_BYTES = IMEM_BYTES - BASE_ADDR;

  state_t          state;
  logic [15:0]     len;
  logic [ADDR_W:0] addr;   // one extra bit so the final increment cannot wrap
  logic [7:0]      csum;
  logic [1:0]      byte_idx;

  logic        accept;
  logic [15:0] hdr_len;
  logic [31:0] hdr_bytes;
  logic        len_bad;
  logic        word_end;
  logic        last_byte;

  assign in_ready = (state != DONE) && (state != ERROR);
  assign accept   = in_valid && in_ready;

  // Length as it will be once len_hi is taken; checked against free space.
  assign hdr_len   = {in_data, len[7:0]};
  assign hdr_bytes = {14'd0, hdr_len, 2'b00};
  assign len_bad   = (hdr_len == 16'd0) || (hdr_bytes > 32'(CAP_BYTES));

  assign word_end  = (byte_idx == 2'(BYTES_PER_WORD - 1));
  // words_loaded < len always holds in DATA, so the +1 cannot wrap.
  assign last_byte = word_end && ((words_loaded + 16'd1) == len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= LEN_LO;
      len          <= '0;
      addr         <= (ADDR_W+1)'(BASE_ADDR);
      csum         <= '0;
      byte_idx     <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        LEN_LO: begin
          if (accept) begin
            len[7:0] <= in_data;
            state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len[15:8] <= in_data;
            if (len_bad) begin
              state <= ERROR;
              error <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= addr[ADDR_W-1:0];
            mem_wdata <= in_data;
            addr      <= addr + 1'b1;
            csum      <= csum ^ in_data;
            byte_idx  <= byte_idx + 2'd1;
            if (word_end) words_loaded <= words_loaded + 16'd1;
            if (last_byte) state <= CSUM;
          end
        end
        CSUM: begin
          if (accept) begin
            if (in_data == csum) begin
              state     <= DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end
        DONE, ERROR: begin
          if (start) begin
            state        <= LEN_LO;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_reset    <= 1'b1;
            words_loaded <= '0;
            csum         <= '0;
            byte_idx     <= '0;
            addr         <= (ADDR_W+1)'(BASE_ADDR);
          end
        end
        default: begin
          state <= LEN_LO;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Hardware program loader: the write-side counterpart to the processor's instruction-fetch read path.
- Receives a framed byte stream over a valid/ready handshake and writes it into the byte-wide, little-endian instruction memory, 4 bytes per instruction word.
- Holds the processor in reset until a frame loads cleanly.
- Sits between a host byte source (UART receiver or test stimulus) and the instruction memory write port, ahead of the processor's reset input.

Parameters:
IMEM_BYTES, 1024, instruction memory size in bytes; must be a multiple of 4.
ADDR_W, 10, byte address width; must equal clog2(IMEM_BYTES).
BASE_ADDR, 0, byte address of the first written byte; must be 4-aligned.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse; re-arms the loader from DONE or ERROR.
in_valid  in  1  byte source has a byte on in_data.
in_data  in  8  stream byte.
in_ready  out  1  loader accepts a byte this cycle.
mem_we  out  1  instruction memory byte write enable.
mem_addr  out  ADDR_W  byte address of the write.
mem_wdata  out  8  byte to write.
cpu_reset  out  1  reset to the processor core; high while loading.
done  out  1  frame loaded and checksum matched.
error  out  1  frame rejected.
words_loaded  out  16  count of complete 4-byte words written in the current frame.

Behaviour:
- Reset (asynchronous, any state, including mid-frame):
  - State goes to LEN_LO.
  - cpu_reset=1, mem_we=0, done=0, error=0, words_loaded=0.
  - Address goes to BASE_ADDR and checksum to 0.
  - Memory contents are not cleared.
- Transfer rule: a byte is accepted on a rising edge where in_valid and in_ready are both 1.
  - in_ready is a registered-state decode: 1 in LEN_LO, LEN_HI, DATA, CSUM; 0 in DONE and ERROR.
  - in_valid may drop at any point; the loader waits indefinitely. There is no timeout.
- Frame format: len_lo, len_hi (16-bit word count N, little-endian), then 4*N payload bytes, then 1 checksum byte.
  - Checksum is the XOR of all payload bytes. Length bytes are excluded.
- States and transitions:
  - LEN_LO: accept byte and store it as N[7:0] -> LEN_HI.
  - LEN_HI: accept byte and store it as N[15:8].
    - If N==0, or 4*N > IMEM_BYTES-BASE_ADDR: go to ERROR.
    - Otherwise: go to DATA.
  - DATA: on each accepted byte:
    - Issue a write on the next cycle: mem_we=1 for exactly one cycle, with mem_addr = current address and mem_wdata = the byte.
    - Address += 1.
    - Checksum ^= byte.
    - After every 4th byte, words_loaded += 1.
    - After byte 4*N: go to CSUM.
  - CSUM: accept byte.
    - Equal to checksum: go to DONE.
    - Not equal: go to ERROR.
  - DONE: done=1, cpu_reset=0 (both registered, high/low from the first cycle in DONE).
  - ERROR: error=1, cpu_reset stays 1.
  - DONE or ERROR with start=1: go to LEN_LO. Clear done, error, words_loaded and checksum, reset address to BASE_ADDR, assert cpu_reset.
  - start is ignored in any other state.
- Byte ordering:
  - Payload byte k goes to address BASE_ADDR+k.
  - The host sends each word LSB first, so word w occupies BASE_ADDR+4w .. +3 in little-endian order, matching the fetch path.
- Write latency:
  - Exactly one cycle from acceptance to mem_we.
  - Back-to-back accepted bytes produce back-to-back writes with no bubbles.
  - The last payload write overlaps the first CSUM cycle.
- No address wrap is possible: the length check in LEN_HI bounds the address.
- The address counter is ADDR_W+1 bits wide internally so the final increment to IMEM_BYTES does not overflow.
- mem_we must be 0 in every state other than the cycle following a DATA acceptance.

Decomposition:
- Shared package (loader_pkg):
  - State enum: LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR.
  - Constant FRAME_HDR_BYTES=2.
  - Constant BYTES_PER_WORD=4.
- No sub-module required. A single FSM plus counters stays within about 200 lines.
- An optional byte-to-word assembler is not used, because the memory is byte-addressed.

Test Plan:
- Load frame N=16 (0x10,0x00) with the stress-program words 0x20080001, 0x20090006, …, 0x20170309, sent LSB first, plus correct XOR -> writes 01,00,08,20 at addresses 0..3 and 09,03,17,20 at 60..63; done=1, words_loaded=16, cpu_reset falls one cycle after CSUM acceptance.
- Same frame with checksum byte XORed with 0x01 -> error=1, done=0, cpu_reset stays 1, in_ready=0; a start pulse returns to LEN_LO with in_ready=1.
- Header N=0 -> ERROR after LEN_HI with no mem_we pulses. Header N=257 with IMEM_BYTES=1024 -> ERROR, no writes.
- Random in_valid gaps (30% idle) on a 4-word frame -> exactly 16 mem_we pulses at addresses 0..15 in order, data identical to the gap-free run.
- Assert reset after payload byte 6 of an 8-word frame -> immediate cpu_reset=1, words_loaded=0, LEN_LO. A following clean 2-word frame loads from BASE_ADDR and reaches done=1.
- Back-to-back valid, N=1 -> mem_we high on 4 consecutive cycles; DONE reached 1 cycle after the checksum byte is accepted.
